// File: rtl/fetch_pkg.sv
// Shared fetch types: FSM states, RV32 control-flow opcodes,
// canonical NOP and the instruction-buffer entry bundle.
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    DRAIN
  } fetch_state_t;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ibuf_entry_t;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Fetch bundle: redirect in, imem req/rsp, decode handshake, flush.
// master = fetch unit side, slave = core/memory environment side.
interface fetch_pc_unit_if;

  logic        redirect_valid_in;
  logic [31:0] redirect_pc_in;
  logic        imem_req_valid_out;
  logic [31:0] imem_req_addr_out;
  logic        imem_req_ready_in;
  logic        imem_rsp_valid_in;
  logic [31:0] imem_rsp_data_in;
  logic        instr_valid_out;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        instr_ready_in;
  logic        flush_out;

  modport master (
    input  redirect_valid_in,
    input  redirect_pc_in,
    output imem_req_valid_out,
    output imem_req_addr_out,
    input  imem_req_ready_in,
    input  imem_rsp_valid_in,
    input  imem_rsp_data_in,
    output instr_valid_out,
    output instr_out,
    output pc_out,
    input  instr_ready_in,
    output flush_out
  );

  modport slave (
    output redirect_valid_in,
    output redirect_pc_in,
    input  imem_req_valid_out,
    input  imem_req_addr_out,
    output imem_req_ready_in,
    output imem_rsp_valid_in,
    output imem_rsp_data_in,
    input  instr_valid_out,
    input  instr_out,
    input  pc_out,
    output instr_ready_in,
    input  flush_out
  );

endinterface

// File: rtl/fetch_ibuf.sv
// Instruction FIFO: clk/rst, clear (sync), push/push_data, pop,
// head (registered storage), count, full, empty.
module fetch_ibuf
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  ibuf_entry_t   push_data,
  input  logic          pop,
  output ibuf_entry_t   head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  ibuf_entry_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // a full buffer may still take a push when the head leaves
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear && !rst) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch front end: owns fetch PC, one outstanding imem request,
// buffers responses for decode, applies redirects with flush pulse.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IBUF_DEPTH = 2
) (
  input logic            clk,
  input logic            rst,
  fetch_pc_unit_if.master bus
);

  localparam int CW = $clog2(IBUF_DEPTH + 1);

  fetch_state_t  state;
  fetch_state_t  state_nxt;
  logic [31:0]   fetch_pc;
  logic [31:0]   req_pc;
  logic          flush_q;
  logic          redir;
  logic          rsp;
  logic          hs;
  logic          push;
  logic          full;
  logic          empty;
  logic [CW-1:0] count_unused;
  logic [1:0]    unused_pc_lsb;
  ibuf_entry_t   push_data;
  ibuf_entry_t   head;

  assign redir         = bus.redirect_valid_in;
  assign rsp           = bus.imem_rsp_valid_in;
  assign unused_pc_lsb = bus.redirect_pc_in[1:0];

  // outstanding request lives only in WAIT/DRAIN, so in REQ
  // the free-slot credit is simply "buffer not full"
  assign bus.imem_req_valid_out =
    (state == REQ) && !full && !rst;
  assign bus.imem_req_addr_out  = fetch_pc;
  assign hs = bus.imem_req_valid_out && bus.imem_req_ready_in;

  assign push      = (state == WAIT) && rsp && !redir;
  assign push_data = '{pc: req_pc, instr: bus.imem_rsp_data_in};

  always_comb begin
    state_nxt = state;
    unique case (state)
      REQ: begin
        if (hs) state_nxt = redir ? DRAIN : WAIT;
      end
      WAIT: begin
        if (rsp)        state_nxt = REQ;
        else if (redir) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (rsp) state_nxt = REQ;
      end
      default: state_nxt = REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= REQ;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      flush_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      flush_q <= redir;
      if (redir) begin
        fetch_pc <= {bus.redirect_pc_in[31:2], 2'b00};
      end else if (hs) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (hs) req_pc <= fetch_pc;
    end
  end

  fetch_ibuf #(
    .DEPTH (IBUF_DEPTH)
  ) u_ibuf (
    .clk       (clk),
    .rst       (rst),
    .clear     (redir),
    .push      (push),
    .push_data (push_data),
    .pop       (bus.instr_ready_in),
    .head      (head),
    .count     (count_unused),
    .full      (full),
    .empty     (empty)
  );

  assign bus.instr_valid_out = !empty;
  assign bus.instr_out       = head.instr;
  assign bus.pc_out          = head.pc;
  assign bus.flush_out       = flush_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios then random traffic,
// checked against an in-order program-stream model.
module tb_fetch_pc_unit;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_pc_unit_if bus ();

  fetch_pc_unit #(
    .RESET_PC   (RPC),
    .IBUF_DEPTH (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic        rst_v;
  logic        redir_v;
  logic [31:0] redir_pc_v;
  logic        rdy_v;
  logic        mem_rdy_v;
  int          lat;

  logic        pend;
  logic [31:0] pend_addr;
  int          pend_cnt;

  logic        s_valid, s_hs, s_rsp, s_ivalid, s_flush;
  logic [31:0] s_addr, s_pc, s_instr;

  logic        prev_redir, prev_rst, have_prev;
  logic [31:0] exp_pc;
  int          n_hs, n_pop, cyc_n;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    logic give;
    give = pend && (pend_cnt == 0);
    rst                   = rst_v;
    bus.redirect_valid_in = redir_v;
    bus.redirect_pc_in    = redir_pc_v;
    bus.instr_ready_in    = rdy_v;
    bus.imem_req_ready_in = mem_rdy_v && !pend;
    bus.imem_rsp_valid_in = give;
    bus.imem_rsp_data_in  = give ? (pend_addr ^ KEY) : 32'hDEAD_BEEF;
    #1;
    s_valid  = bus.imem_req_valid_out;
    s_addr   = bus.imem_req_addr_out;
    s_hs     = s_valid && bus.imem_req_ready_in;
    s_rsp    = give;
    s_ivalid = bus.instr_valid_out;
    s_pc     = bus.pc_out;
    s_instr  = bus.instr_out;
    s_flush  = bus.flush_out;
  endtask

  task automatic pre();
    @(negedge clk);
    drive();
  endtask

  task automatic post();
    if (have_prev)
      chk("flush", 32'(s_flush), 32'(prev_redir && !prev_rst));
    if (s_hs) begin
      chk("addr_align", {30'd0, s_addr[1:0]}, 32'd0);
      n_hs++;
    end
    if (!rst_v && !redir_v && s_ivalid === 1'b1 && rdy_v) begin
      chk("pop_pc", s_pc, exp_pc);
      chk("pop_instr", s_instr, exp_pc ^ KEY);
      exp_pc = exp_pc + 32'd4;
      n_pop++;
    end
    if (rst_v) exp_pc = RPC;
    else if (redir_v) exp_pc = {redir_pc_v[31:2], 2'b00};
    if (s_rsp) pend = 1'b0;
    else if (pend && pend_cnt > 0) pend_cnt--;
    if (s_hs) begin
      pend      = 1'b1;
      pend_addr = s_addr;
      pend_cnt  = lat - 1;
    end
    prev_redir = redir_v;
    prev_rst   = rst_v;
    have_prev  = 1'b1;
    cyc_n++;
    @(posedge clk);
  endtask

  task automatic until_hs(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      pre();
      ok = s_hs;
      post();
    end
  endtask

  task automatic reset_pulse();
    rst_v = 1'b1;
    pre();
    post();
    rst_v = 1'b0;
  endtask

  initial begin
    logic ok;
    logic found;
    int   c0, h0, p0;

    rst_v = 1'b1; redir_v = 1'b0; redir_pc_v = '0;
    rdy_v = 1'b1; mem_rdy_v = 1'b1; lat = 1;
    pend = 1'b0; pend_addr = '0; pend_cnt = 0;
    have_prev = 1'b0; prev_redir = 1'b0; prev_rst = 1'b1;
    exp_pc = RPC; n_hs = 0; n_pop = 0; cyc_n = 0;

    // reset values and ideal-memory streaming
    pre(); post();
    pre();
    chk("rst_req_valid", 32'(s_valid), 32'd0);
    chk("rst_ivalid", 32'(s_ivalid), 32'd0);
    chk("rst_flush", 32'(s_flush), 32'd0);
    chk("rst_pc", s_pc, 32'd0);
    chk("rst_instr", s_instr, 32'd0);
    post();
    rst_v = 1'b0;
    n_pop = 0;
    pre();
    chk("t1_first_hs", 32'(s_hs), 32'd1);
    chk("t1_addr0", s_addr, 32'h0);
    c0 = cyc_n;
    post();
    until_hs(5, ok);
    chk("t1_hs1", 32'(ok), 32'd1);
    chk("t1_addr4", s_addr, 32'h4);
    chk("t1_rate", 32'(cyc_n - 1 - c0), 32'd2);
    until_hs(5, ok);
    chk("t1_addr8", s_addr, 32'h8);
    repeat (2) begin pre(); post(); end
    chk("t1_pops", 32'(n_pop >= 2), 32'd1);

    // stalled decode: credit limits fetch to two entries
    reset_pulse();
    rdy_v = 1'b0;
    h0 = n_hs;
    repeat (10) begin pre(); post(); end
    chk("t2_hs_count", 32'(n_hs - h0), 32'd2);
    chk("t2_req_idle", 32'(s_valid), 32'd0);
    chk("t2_ivalid", 32'(s_ivalid), 32'd1);
    chk("t2_head_pc", s_pc, 32'h0);
    lat = 3;
    rdy_v = 1'b1;
    p0 = n_pop;
    until_hs(6, ok);
    chk("t2_resume", 32'(ok), 32'd1);
    chk("t2_addr8", s_addr, 32'h8);
    chk("t2_pops", 32'(n_pop - p0), 32'd2);

    // redirect while waiting on 0x8
    redir_v = 1'b1; redir_pc_v = 32'h100;
    pre(); post();
    redir_v = 1'b0;
    pre();
    chk("t3_flush", 32'(s_flush), 32'd1);
    chk("t3_empty", 32'(s_ivalid), 32'd0);
    post();
    until_hs(8, ok);
    chk("t3_hs", 32'(ok), 32'd1);
    chk("t3_addr", s_addr, 32'h100);

    // redirect on the same cycle as the 0xC handshake
    lat = 1;
    reset_pulse();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      pre();
      if (s_hs && s_addr == 32'hC) begin
        redir_v = 1'b1; redir_pc_v = 32'h203;
        drive();
        found = 1'b1;
      end
      post();
    end
    chk("t4_found", 32'(found), 32'd1);
    redir_v = 1'b0;
    pre();
    chk("t4_drain_idle", 32'(s_valid), 32'd0);
    post();
    pre();
    chk("t4_hs", 32'(s_hs), 32'd1);
    chk("t4_addr", s_addr, 32'h200);
    post();

    // redirect coinciding with a response in WAIT
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      pre();
      if (s_rsp) begin
        redir_v = 1'b1; redir_pc_v = 32'h300;
        drive();
        found = 1'b1;
      end
      post();
    end
    chk("t5_found", 32'(found), 32'd1);
    redir_v = 1'b0;
    pre();
    chk("t5_hs", 32'(s_hs), 32'd1);
    chk("t5_addr", s_addr, 32'h300);
    post();

    // reset while waiting, late response must be ignored
    lat = 3;
    until_hs(6, ok);
    rst_v = 1'b1;
    pre();
    chk("t6_rst_req", 32'(s_valid), 32'd0);
    post();
    rst_v = 1'b0;
    pre();
    chk("t6_ivalid", 32'(s_ivalid), 32'd0);
    chk("t6_flush", 32'(s_flush), 32'd0);
    chk("t6_pc", s_pc, 32'd0);
    chk("t6_instr", s_instr, 32'd0);
    post();
    until_hs(10, ok);
    chk("t6_hs", 32'(ok), 32'd1);
    chk("t6_addr", s_addr, RPC);
    chk("t6_no_stale", 32'(s_ivalid), 32'd0);

    // PC wrap at the top of the address space
    lat = 1;
    redir_v = 1'b1; redir_pc_v = 32'hFFFF_FFFE;
    pre(); post();
    redir_v = 1'b0;
    until_hs(10, ok);
    chk("wrap_top", s_addr, 32'hFFFF_FFFC);
    until_hs(10, ok);
    chk("wrap_zero", s_addr, 32'h0);
    repeat (6) begin pre(); post(); end

    // random traffic against the stream model
    p0 = n_pop;
    for (int i = 0; i < 3000; i++) begin
      rst_v      = ($urandom % 200) == 0;
      redir_v    = ($urandom % 25) == 0;
      redir_pc_v = $urandom;
      rdy_v      = ($urandom % 3) != 0;
      mem_rdy_v  = ($urandom % 4) != 0;
      lat        = int'($urandom_range(1, 3));
      pre();
      post();
    end
    chk("rand_progress", 32'(n_pop - p0 > 300), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
